expansion_uart_host: RTL and testbench
======================================

// Module: expansion_uart_host
// PURPOSE
//  Host-side IO-bus initiator for the UART expansion card. Runs in i_clkDesign.
//  Takes TX bytes on a valid/ready stream and writes them to the card's TX FIFO
//  once a poll shows it is not full. Polls the card's RX FIFO and delivers
//  received bytes on a valid/ready stream. Sits between the CPU IO unit and the
//  shared expansion IO bus.
// PARAMETERS
//  SLOT        1   card slot; bus address = {SLOT[4:0], offset[2:0]}
//  STROBE_RD   2   cycles o_ioNOE is held low per read, 1..4
//  POLL_GAP    4   idle cycles after a poll that found nothing to do, 0..15
// PORTS
//  i_clkDesign  in   1  design clock; all logic on its rising edge
//  i_resetn     in   1  asynchronous, active-low reset
//  i_txData     in   8  byte to transmit
//  i_txValid    in   1  i_txData valid
//  o_txReady    out  1  byte accepted when i_txValid & o_txReady
//  o_rxData     out  8  received byte
//  o_rxValid    out  1  o_rxData valid; held until i_rxReady
//  i_rxReady    in   1  consumer accepts o_rxData
//  o_ioNCE      out  1  IO chip enable, active low
//  o_ioAddress  out  8  IO address
//  o_ioNOE      out  1  IO read strobe, active low
//  o_ioNWE      out  1  IO write strobe, active low
//  o_bus        out  8  write data
//  o_busOE      out  1  host drives o_bus onto the shared bus
//  i_bus        in   8  read data from the shared bus
//  o_busy       out  1  a bus cycle is in progress (o_ioNCE low)
// BEHAVIOUR
//  Register map, offsets: 1 = RX empty (bit0), 2 = TX full (bit0), 3 = data (W: TX push, R: RX pop).
//  Reset values: o_ioNCE/o_ioNOE/o_ioNWE = 1, o_ioAddress = 0, o_bus = 0, o_busOE = 0,
//   o_txReady = 0, o_rxValid = 0, o_rxData = 0, o_busy = 0. All outputs are registered.
//  Bus cycle, any access: SETUP 1 cycle (NCE low, address stable, strobes high) -> STROBE -> HOLD 1
//   cycle (strobes high, NCE low, address stable) -> NCE high for at least 1 cycle before the next access.
//  Read STROBE: NOE low for exactly STROBE_RD cycles. i_bus is registered at the rising edge that ends
//   the last NOE-low cycle.
//  Write STROBE: NWE low for exactly 1 cycle. o_busOE is high from SETUP through HOLD; o_bus is stable
//   throughout. o_busOE is never high while NOE is low.
//  TX byte buffer (1 entry): o_txReady = ~txBufFull. On accept, the byte is latched and txBufFull is set.
//  RX holding register (1 entry): o_rxValid = rxHoldFull. Cleared on o_rxValid & i_rxReady.
//  Service FSM: IDLE, TX_POLL, TX_WRITE, RX_POLL, RX_READ, GAP.
//   IDLE: candidates are TX (txBufFull) and RX (~rxHoldFull). Round-robin between them; the one served
//    last loses a tie. With no candidate, stay in IDLE.
//   TX_POLL: read offset 2. bit0 = 1 -> GAP; bit0 = 0 -> TX_WRITE.
//   TX_WRITE: write the buffered byte to offset 3, clear txBufFull at HOLD -> IDLE.
//   RX_POLL: read offset 1. bit0 = 1 -> GAP; bit0 = 0 -> RX_READ.
//   RX_READ: read offset 3, load the holding register, set rxHoldFull -> IDLE.
//   GAP: wait POLL_GAP cycles -> IDLE. POLL_GAP = 0 passes straight through in 1 cycle.
//  RX_READ is only entered while rxHoldFull = 0, so a received byte is never overwritten.
//  Simultaneous events: an RX pop and a new RX load in the same cycle -> load wins, rxValid stays 1.
//   A TX accept is possible in the same cycle that TX_WRITE clears txBufFull.
//  Bits [7:1] of status reads are ignored.
//  Reset mid-cycle: all strobes and NCE go high immediately (asynchronous); both buffers are emptied.
//  Latency: byte accepted -> NWE low is 5 + STROBE_RD cycles minimum (idle bus, TX FIFO not full).
// STRUCTURE
//  Shared package expansion_io_pkg: offset constants UART_OFS_RXEMPTY = 3'h1, UART_OFS_TXFULL = 3'h2,
//   UART_OFS_DATA = 3'h3; slot number UART_SLOT = 5'd1; a bus-op enum {OP_RD, OP_WR}.
//  Sub-module io_bus_cycle: start/op/addr/wdata in, done/rdata out. Generates the SETUP/STROBE/HOLD/
//   release timing. Reusable by later expansion-card hosts.
// TESTING
//  1. Reset with strobes low, then release -> NCE/NOE/NWE = 1, o_busOE = 0, o_txReady = 0 for 1 cycle, then 1.
//  2. Send 0x41, card TX not full -> poll at addr 0x0A, then write at 0x0B; NWE low exactly 1 cycle with o_bus = 0x41.
//  3. Card TX full for 3 polls, then clear -> 3 polls at 0x0A with POLL_GAP = 4 idle cycles between; one write; byte not lost.
//  4. Card RX holds 0x55, 0xAA, i_rxReady = 0 -> 0x55 presented and held; no read of addr 0x0B until the pop; then 0xAA.
//  5. TX byte pending and RX data present -> accesses alternate TX and RX; neither side gets two services in a row.
//  6. Assert i_resetn low during NOE low of an RX_READ -> NOE high at once; o_rxValid = 0; after release the poll restarts at 0x09.

Source files
------------

// File: rtl/expansion_io_pkg.sv
// Shared definitions for expansion-card IO-bus hosts: register offsets, slot and bus-op type.
// No logic; address helper builds {slot, offset}.
package expansion_io_pkg;

    localparam logic [2:0] UART_OFS_RXEMPTY = 3'h1;
    localparam logic [2:0] UART_OFS_TXFULL  = 3'h2;
    localparam logic [2:0] UART_OFS_DATA    = 3'h3;
    localparam logic [4:0] UART_SLOT        = 5'd1;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } busOp_t;

    function automatic logic [7:0] ioAddr(input logic [4:0] slot, input logic [2:0] ofs);
        return {slot, ofs};
    endfunction

endpackage

// File: rtl/io_bus_cycle.sv
// One IO-bus access: SETUP 1, STROBE (STROBE_RD reads / 1 write), HOLD 1, RELEASE 1 with done; all pins registered.
// Start is taken only in IDLE or RELEASE, so back-to-back accesses keep exactly one NCE-high cycle.
module io_bus_cycle
    import expansion_io_pkg::*;
#(
    parameter int STROBE_RD = 2
) (
    input  logic       i_clkDesign,
    input  logic       i_resetn,
    input  logic       i_start,
    input  busOp_t     i_op,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_bus,
    output logic       o_done,
    output logic       o_strobeEnd,
    output logic [7:0] o_rdata,
    output logic       o_ioNCE,
    output logic [7:0] o_ioAddress,
    output logic       o_ioNOE,
    output logic       o_ioNWE,
    output logic [7:0] o_bus,
    output logic       o_busOE,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD,
        BUS_RELEASE
    } busState_t;

    localparam logic [1:0] STROBE_LAST = 2'(STROBE_RD - 1);

    busState_t  state, stateNext;
    busOp_t     op, opNext;
    logic [1:0] strobeCnt, strobeCntNext;
    logic [7:0] addrNext, wdataNext;
    logic       lastStrobe;
    logic       activeNext;

    always_comb begin
        stateNext     = state;
        opNext        = op;
        strobeCntNext = strobeCnt;
        addrNext      = o_ioAddress;
        wdataNext     = o_bus;
        lastStrobe    = (state == BUS_STROBE) && ((op == OP_WR) || (strobeCnt == STROBE_LAST));
        case (state)
            BUS_IDLE, BUS_RELEASE: begin
                if (i_start) begin
                    stateNext = BUS_SETUP;
                    opNext    = i_op;
                    addrNext  = i_addr;
                    if (i_op == OP_WR) begin
                        wdataNext = i_wdata;
                    end
                end else begin
                    stateNext = BUS_IDLE;
                end
            end
            BUS_SETUP: begin
                stateNext     = BUS_STROBE;
                strobeCntNext = 2'd0;
            end
            BUS_STROBE: begin
                if (lastStrobe) begin
                    stateNext = BUS_HOLD;
                end else begin
                    strobeCntNext = strobeCnt + 2'd1;
                end
            end
            BUS_HOLD: stateNext = BUS_RELEASE;
            default:  stateNext = BUS_IDLE;
        endcase
        activeNext = (stateNext == BUS_SETUP) || (stateNext == BUS_STROBE) || (stateNext == BUS_HOLD);
    end

    assign o_done      = (state == BUS_RELEASE);
    assign o_strobeEnd = lastStrobe;

    // Pins are computed from the next state so every bus output comes straight from a flop.
    always_ff @(posedge i_clkDesign or negedge i_resetn) begin
        if (!i_resetn) begin
            state       <= BUS_IDLE;
            op          <= OP_RD;
            strobeCnt   <= 2'd0;
            o_rdata     <= 8'h00;
            o_ioNCE     <= 1'b1;
            o_ioAddress <= 8'h00;
            o_ioNOE     <= 1'b1;
            o_ioNWE     <= 1'b1;
            o_bus       <= 8'h00;
            o_busOE     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= stateNext;
            op          <= opNext;
            strobeCnt   <= strobeCntNext;
            o_ioAddress <= addrNext;
            o_bus       <= wdataNext;
            o_ioNCE     <= !activeNext;
            o_busy      <= activeNext;
            o_ioNOE     <= !((stateNext == BUS_STROBE) && (opNext == OP_RD));
            o_ioNWE     <= !((stateNext == BUS_STROBE) && (opNext == OP_WR));
            o_busOE     <= activeNext && (opNext == OP_WR);
            if (lastStrobe && (op == OP_RD)) begin
                o_rdata <= i_bus;
            end
        end
    end

endmodule

// File: rtl/expansion_uart_host.sv
// UART expansion-card host: 1-entry TX buffer and RX holding register, round-robin polled over the IO bus.
// Accept -> NWE low is 5 + STROBE_RD cycles minimum; o_txReady drops while the TX byte waits, o_rxValid holds until i_rxReady.
module expansion_uart_host
    import expansion_io_pkg::*;
#(
    parameter int SLOT      = int'(UART_SLOT),
    parameter int STROBE_RD = 2,
    parameter int POLL_GAP  = 4
) (
    input  logic       i_clkDesign,
    input  logic       i_resetn,
    input  logic [7:0] i_txData,
    input  logic       i_txValid,
    output logic       o_txReady,
    output logic [7:0] o_rxData,
    output logic       o_rxValid,
    input  logic       i_rxReady,
    output logic       o_ioNCE,
    output logic [7:0] o_ioAddress,
    output logic       o_ioNOE,
    output logic       o_ioNWE,
    output logic [7:0] o_bus,
    output logic       o_busOE,
    input  logic [7:0] i_bus,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        TX_POLL,
        TX_WRITE,
        RX_POLL,
        RX_READ,
        GAP
    } svcState_t;

    localparam logic [4:0] SLOT_NUM     = 5'(SLOT);
    localparam logic [7:0] ADDR_RXEMPTY = ioAddr(SLOT_NUM, UART_OFS_RXEMPTY);
    localparam logic [7:0] ADDR_TXFULL  = ioAddr(SLOT_NUM, UART_OFS_TXFULL);
    localparam logic [7:0] ADDR_DATA    = ioAddr(SLOT_NUM, UART_OFS_DATA);
    localparam logic [3:0] GAP_LOAD     = (POLL_GAP > 1) ? 4'(POLL_GAP - 1) : 4'd0;

    svcState_t  state, stateNext;
    logic [7:0] txBuf;
    logic       txBufFull, txBufFullNext;
    logic       txAccept, txClear;
    logic       rxHoldFull, rxLoad;
    logic       lastWasTx, lastWasTxNext;
    logic [3:0] gapCnt, gapCntNext;

    logic       busStart, busDone, busStrobeEnd;
    busOp_t     busOp;
    logic [7:0] busAddr, busRdata;

    io_bus_cycle #(
        .STROBE_RD (STROBE_RD)
    ) busCycle (
        .i_clkDesign (i_clkDesign),
        .i_resetn    (i_resetn),
        .i_start     (busStart),
        .i_op        (busOp),
        .i_addr      (busAddr),
        .i_wdata     (txBuf),
        .i_bus       (i_bus),
        .o_done      (busDone),
        .o_strobeEnd (busStrobeEnd),
        .o_rdata     (busRdata),
        .o_ioNCE     (o_ioNCE),
        .o_ioAddress (o_ioAddress),
        .o_ioNOE     (o_ioNOE),
        .o_ioNWE     (o_ioNWE),
        .o_bus       (o_bus),
        .o_busOE     (o_busOE),
        .o_busy      (o_busy)
    );

    always_comb begin
        stateNext     = state;
        busStart      = 1'b0;
        busOp         = OP_RD;
        busAddr       = ADDR_RXEMPTY;
        gapCntNext    = gapCnt;
        lastWasTxNext = lastWasTx;
        txClear       = 1'b0;
        rxLoad        = 1'b0;
        case (state)
            IDLE: begin
                // TX wins unless RX is also waiting and TX was the last one served.
                if (txBufFull && (rxHoldFull || !lastWasTx)) begin
                    busStart      = 1'b1;
                    busAddr       = ADDR_TXFULL;
                    stateNext     = TX_POLL;
                    lastWasTxNext = 1'b1;
                end else if (!rxHoldFull) begin
                    busStart      = 1'b1;
                    busAddr       = ADDR_RXEMPTY;
                    stateNext     = RX_POLL;
                    lastWasTxNext = 1'b0;
                end
            end
            TX_POLL: begin
                if (busDone) begin
                    if (busRdata[0]) begin
                        stateNext  = GAP;
                        gapCntNext = GAP_LOAD;
                    end else begin
                        busStart  = 1'b1;
                        busOp     = OP_WR;
                        busAddr   = ADDR_DATA;
                        stateNext = TX_WRITE;
                    end
                end
            end
            TX_WRITE: begin
                txClear = busStrobeEnd;
                if (busDone) begin
                    stateNext = IDLE;
                end
            end
            RX_POLL: begin
                if (busDone) begin
                    if (busRdata[0]) begin
                        stateNext  = GAP;
                        gapCntNext = GAP_LOAD;
                    end else begin
                        busStart  = 1'b1;
                        busAddr   = ADDR_DATA;
                        stateNext = RX_READ;
                    end
                end
            end
            RX_READ: begin
                if (busDone) begin
                    rxLoad    = 1'b1;
                    stateNext = IDLE;
                end
            end
            GAP: begin
                if (gapCnt == 4'd0) begin
                    stateNext = IDLE;
                end else begin
                    gapCntNext = gapCnt - 4'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The write data is already latched in the bus cycle, so the buffer frees up as the strobe ends.
    assign txAccept      = i_txValid && o_txReady;
    assign txBufFullNext = (txBufFull && !txClear) || txAccept;
    assign o_rxValid     = rxHoldFull;

    always_ff @(posedge i_clkDesign or negedge i_resetn) begin
        if (!i_resetn) begin
            state      <= IDLE;
            gapCnt     <= 4'd0;
            lastWasTx  <= 1'b0;
            txBuf      <= 8'h00;
            txBufFull  <= 1'b0;
            o_txReady  <= 1'b0;
            rxHoldFull <= 1'b0;
            o_rxData   <= 8'h00;
        end else begin
            state     <= stateNext;
            gapCnt    <= gapCntNext;
            lastWasTx <= lastWasTxNext;
            txBufFull <= txBufFullNext;
            o_txReady <= !txBufFullNext;
            if (txAccept) begin
                txBuf <= i_txData;
            end
            if (rxLoad) begin
                rxHoldFull <= 1'b1;
                o_rxData   <= busRdata;
            end else if (rxHoldFull && i_rxReady) begin
                rxHoldFull <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_expansion_uart_host.sv
// Directed bench for expansion_uart_host with a behavioural UART card on the IO bus.
module tb_expansion_uart_host;

    localparam int STROBE_RD = 2;
    localparam int POLL_GAP  = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady = 1'b0;
    logic       nce, noe, nwe, busOE, busy;
    logic [7:0] ioAddress, busOut, busIn;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // card model: tasks write rxMem/rxWr/txFullUntil, the monitor writes rxRd/txPolls
    logic [7:0] rxMem [0:15];
    int rxWr = 0, rxRd = 0, txPolls = 0, txFullUntil = 0;

    logic [7:0] logAddr[$];
    bit         logWr[$];
    logic [7:0] logDat[$];
    int         logCyc[$];
    logic [7:0] rxGot[$];
    int viol = 0, noeLen = 0, nweLen = 0;
    logic pNce = 1'b1, pNoe = 1'b1, pNwe = 1'b1;

    expansion_uart_host #(.SLOT(1), .STROBE_RD(STROBE_RD), .POLL_GAP(POLL_GAP)) dut (
        .i_clkDesign (clk),
        .i_resetn    (resetn),
        .i_txData    (txData),
        .i_txValid   (txValid),
        .o_txReady   (txReady),
        .o_rxData    (rxData),
        .o_rxValid   (rxValid),
        .i_rxReady   (rxReady),
        .o_ioNCE     (nce),
        .o_ioAddress (ioAddress),
        .o_ioNOE     (noe),
        .o_ioNWE     (nwe),
        .o_bus       (busOut),
        .o_busOE     (busOE),
        .i_bus       (busIn),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // status reads carry junk in bits [7:1]
    assign busIn = (ioAddress == 8'h09) ? {7'b1010101, rxRd == rxWr} :
                   (ioAddress == 8'h0A) ? {7'b0110011, txPolls < txFullUntil} :
                   (ioAddress == 8'h0B) ? rxMem[rxRd % 16] : 8'h00;

    always @(negedge clk) begin
        if (!nwe && pNwe) begin
            logAddr.push_back(ioAddress); logWr.push_back(1'b1);
            logDat.push_back(busOut); logCyc.push_back(cyc);
            if (pNce || !busOE) viol++;
        end
        if (!noe && pNoe) begin
            logAddr.push_back(ioAddress); logWr.push_back(1'b0);
            logDat.push_back(busIn); logCyc.push_back(cyc);
            if (pNce) viol++;
        end
        if (!noe && busOE) viol++;
        if (noe && !pNoe && resetn) begin
            if (noeLen != STROBE_RD || nce) viol++;
            if (ioAddress == 8'h0B) rxRd++;
            if (ioAddress == 8'h0A) txPolls++;
        end
        if (nwe && !pNwe && resetn) begin
            if (nweLen != 1 || nce) viol++;
        end
        noeLen = noe ? 0 : noeLen + 1;
        nweLen = nwe ? 0 : nweLen + 1;
        if (rxValid && rxReady) rxGot.push_back(rxData);
        pNce = nce; pNoe = noe; pNwe = nwe;
    end

    function automatic int findWrite(input int from, input int nth);
        int seen = 0;
        for (int j = from; j < logAddr.size(); j++) begin
            if (logWr[j]) begin
                if (seen == nth) return j;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int countReads(input int from, input logic [7:0] addr);
        int n = 0;
        for (int j = from; j < logAddr.size(); j++)
            if (!logWr[j] && logAddr[j] == addr) n++;
        return n;
    endfunction

    task automatic sendByte(input logic [7:0] b, output int acc);
        acc = -1;
        @(negedge clk);
        txData = b;
        txValid = 1'b1;
        for (int i = 0; i < 300 && acc < 0; i++) begin
            if (txReady === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        txValid = 1'b0;
    endtask

    task automatic pushCard(input logic [7:0] b);
        rxMem[rxWr % 16] = b;
        rxWr++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (nce !== 1'b1 || noe !== 1'b1 || nwe !== 1'b1) begin
            errors++; $display("FAIL reset_strobes nce/noe/nwe=%b%b%b required 111", nce, noe, nwe);
        end
        checks++;
        if (busOE !== 1'b0 || txReady !== 1'b0 || rxValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags busOE/txReady/rxValid/busy=%b%b%b%b required 0000", busOE, txReady, rxValid, busy);
        end
        checks++;
        if (ioAddress !== 8'h00 || busOut !== 8'h00 || rxData !== 8'h00) begin
            errors++; $display("FAIL reset_data addr=%h bus=%h rxData=%h required 00 00 00", ioAddress, busOut, rxData);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (txReady !== 1'b0) begin
            errors++; $display("FAIL release_ready_early got %b required 0", txReady);
        end
        @(negedge clk);
        checks++;
        if (txReady !== 1'b1) begin
            errors++; $display("FAIL release_ready_late got %b required 1", txReady);
        end
    endtask

    task automatic test_tx_single();
        int start, acc, w;
        start = logAddr.size();
        txFullUntil = txPolls;
        sendByte(8'h41, acc);
        checks++;
        if (acc < 0) begin errors++; $display("FAIL tx1_accept got timeout required accept"); end
        w = -1;
        for (int i = 0; i < 300 && w < 0; i++) begin @(negedge clk); w = findWrite(start, 0); end
        checks++;
        if (w < 1) begin
            errors++; $display("FAIL tx1_write_seen got index %0d required write", w);
        end else begin
            checks++;
            if (logAddr[w] !== 8'h0B || logDat[w] !== 8'h41) begin
                errors++; $display("FAIL tx1_write got addr %h data %h required 0b 41", logAddr[w], logDat[w]);
            end
            checks++;
            if (logAddr[w-1] !== 8'h0A || logWr[w-1] !== 1'b0) begin
                errors++; $display("FAIL tx1_poll got addr %h wr %b required 0a read", logAddr[w-1], logWr[w-1]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_rx_hold();
        int start;
        start = logAddr.size();
        pushCard(8'h55);
        pushCard(8'hAA);
        rxReady = 1'b0;
        for (int i = 0; i < 300 && !rxValid; i++) @(negedge clk);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'h55) begin
            errors++; $display("FAIL rx_first got valid %b data %h required 1 55", rxValid, rxData);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'h55) begin
            errors++; $display("FAIL rx_held got valid %b data %h required 1 55", rxValid, rxData);
        end
        checks++;
        if (countReads(start, 8'h0B) != 1) begin
            errors++; $display("FAIL rx_no_overread got %0d data reads required 1", countReads(start, 8'h0B));
        end
        rxReady = 1'b1;
        @(posedge clk);
        #1;
        rxReady = 1'b0;
        checks++;
        if (rxValid !== 1'b0) begin errors++; $display("FAIL rx_pop got valid %b required 0", rxValid); end
        for (int i = 0; i < 300 && !rxValid; i++) @(negedge clk);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'hAA || countReads(start, 8'h0B) != 2) begin
            errors++; $display("FAIL rx_second got valid %b data %h reads %0d required 1 aa 2",
                               rxValid, rxData, countReads(start, 8'h0B));
        end
        repeat (5) @(negedge clk);
    endtask

    // RX holding register stays full here, so only TX is ever a candidate
    task automatic test_tx_full_retry();
        int start, acc, w;
        bit gapOk;
        start = logAddr.size();
        txFullUntil = txPolls + 3;
        sendByte(8'h3C, acc);
        checks++;
        if (acc < 0) begin errors++; $display("FAIL full_accept got timeout required accept"); end
        w = -1;
        for (int i = 0; i < 400 && w < 0; i++) begin @(negedge clk); w = findWrite(start, 0); end
        checks++;
        if (w != start + 4 || countReads(start, 8'h0A) != 4) begin
            errors++; $display("FAIL full_polls got write at +%0d polls %0d required +4 4", w - start, countReads(start, 8'h0A));
        end else begin
            gapOk = 1'b1;
            for (int k = 0; k < 3; k++)
                if (logCyc[start+k+1] - logCyc[start+k] != 10) gapOk = 1'b0;
            checks++;
            if (!gapOk) begin
                errors++; $display("FAIL full_gap got spacing %0d required 10", logCyc[start+1] - logCyc[start]);
            end
            checks++;
            if (logDat[w] !== 8'h3C || logCyc[w] - logCyc[w-1] != 5) begin
                errors++; $display("FAIL full_write got data %h spacing %0d required 3c 5", logDat[w], logCyc[w] - logCyc[w-1]);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_tx_latency();
        int start, acc, w;
        start = logAddr.size();
        txFullUntil = txPolls;
        sendByte(8'h5A, acc);
        w = -1;
        for (int i = 0; i < 200 && w < 0; i++) begin @(negedge clk); w = findWrite(start, 0); end
        checks++;
        if (w < 0 || acc < 0) begin
            errors++; $display("FAIL latency_seen got write %0d accept %0d required both", w, acc);
        end else begin
            checks++;
            if (logCyc[w] - acc != 7 || logDat[w] !== 8'h5A) begin
                errors++; $display("FAIL latency got %0d cycles data %h required 7 5a", logCyc[w] - acc, logDat[w]);
            end
        end
        rxReady = 1'b1;
        @(posedge clk);
        #1;
        rxReady = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int start, gotStart, acc, wLast, firstT, prevKind, same, accFails;
        logic [7:0] txBytes [0:2];
        logic [7:0] rxBytes [0:2];
        txBytes[0] = 8'hC1; txBytes[1] = 8'hC2; txBytes[2] = 8'hC3;
        rxBytes[0] = 8'h11; rxBytes[1] = 8'h22; rxBytes[2] = 8'h33;
        start = logAddr.size();
        gotStart = rxGot.size();
        rxReady = 1'b1;
        for (int k = 0; k < 3; k++) pushCard(rxBytes[k]);
        accFails = 0;
        for (int k = 0; k < 3; k++) begin
            sendByte(txBytes[k], acc);
            if (acc < 0) accFails++;
        end
        for (int i = 0; i < 600 && (findWrite(start, 2) < 0 || rxGot.size() < gotStart + 3); i++) @(negedge clk);
        wLast = findWrite(start, 2);
        checks++;
        if (accFails != 0 || wLast < 0 || rxGot.size() < gotStart + 3) begin
            errors++; $display("FAIL b2b_done got accFails %0d lastWrite %0d rx %0d required 0 found 3",
                               accFails, wLast, rxGot.size() - gotStart);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (logDat[findWrite(start, k)] !== txBytes[k] || rxGot[gotStart+k] !== rxBytes[k]) begin
                    errors++; $display("FAIL b2b_data%0d got tx %h rx %h required %h %h", k,
                                       logDat[findWrite(start, k)], rxGot[gotStart+k], txBytes[k], rxBytes[k]);
                end
            end
            firstT = -1; prevKind = -1; same = 0;
            for (int j = start; j <= wLast; j++) begin
                if (!logWr[j] && (logAddr[j] == 8'h0A || logAddr[j] == 8'h09)) begin
                    if (logAddr[j] == 8'h0A && firstT < 0) firstT = j;
                    if (firstT >= 0) begin
                        if ((logAddr[j] == 8'h0A ? 1 : 0) == prevKind) same++;
                        prevKind = (logAddr[j] == 8'h0A) ? 1 : 0;
                    end
                end
            end
            checks++;
            if (same != 0 || countReads(firstT, 8'h09) < 2) begin
                errors++; $display("FAIL b2b_alternate got %0d repeats %0d rx polls required 0 >=2", same, countReads(firstT, 8'h09));
            end
        end
        rxReady = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int start;
        bit found;
        found = 1'b0;
        pushCard(8'h77);
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (noe === 1'b0 && ioAddress === 8'h0B) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_read_seen got none required data read"); end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (noe !== 1'b1 || nce !== 1'b1 || nwe !== 1'b1 || busOE !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_async got noe %b nce %b nwe %b oe %b busy %b required 1 1 1 0 0", noe, nce, nwe, busOE, busy);
        end
        checks++;
        if (rxValid !== 1'b0 || txReady !== 1'b0) begin
            errors++; $display("FAIL mid_buffers got rxValid %b txReady %b required 0 0", rxValid, txReady);
        end
        repeat (2) @(negedge clk);
        start = logAddr.size();
        resetn = 1'b1;
        for (int i = 0; i < 100 && logAddr.size() <= start; i++) @(negedge clk);
        checks++;
        if (logAddr.size() <= start) begin
            errors++; $display("FAIL mid_restart got no access required 09 read");
        end else if (logAddr[start] !== 8'h09 || logWr[start] !== 1'b0) begin
            errors++; $display("FAIL mid_restart got addr %h wr %b required 09 read", logAddr[start], logWr[start]);
        end
        for (int i = 0; i < 300 && !rxValid; i++) @(negedge clk);
        checks++;
        if (rxValid !== 1'b1 || rxData !== 8'h77) begin
            errors++; $display("FAIL mid_byte_kept got valid %b data %h required 1 77", rxValid, rxData);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bus_protocol got %0d violations required 0", viol); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_rx_hold();
        test_tx_full_retry();
        test_tx_latency();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
